// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: tracks oversample edge and bit position, drives checker enables.
// Optional parity bit support is built when UART_RX_PARITY_SUPPORT_EN is defined.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      start_glitch,
    input  logic                      parity_error,
    input  logic                      stop_error,
    output logic                      data_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stop_check_enable,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      data_valid,
    output logic                      frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_SUPPORT_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                    r_state, w_next;
    logic [PRESCALE_WIDTH-1:0] r_edge, r_prescale;
    logic [3:0]                r_bit;
    logic                      r_err, r_data_valid, r_frame_error;
    logic [PRESCALE_WIDTH-1:0] w_s, w_l;
    logic                      w_last, w_past_s;

`ifdef UART_RX_PARITY_SUPPORT_EN
    logic                      r_par_en;
`else
    logic                      w_unused_par;
    assign w_unused_par = PAR_EN ^ parity_error;
`endif

    // S is the first edge at which the sampler's majority vote has settled.
    assign w_s      = (r_prescale >> 1) + PRESCALE_WIDTH'(2);
    assign w_l      = r_prescale - PRESCALE_WIDTH'(1);
    assign w_last   = (r_edge == w_l);
    assign w_past_s = (r_edge >= w_s);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        data_samp_en      = 1'b0;
        deser_en          = 1'b0;
        strt_chk_en       = 1'b0;
        par_chk_en        = 1'b0;
        stop_check_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (!RX_IN) w_next = START;
            end
            START: begin
                data_samp_en = 1'b1;
                strt_chk_en  = w_past_s;
                if (w_last) w_next = start_glitch ? IDLE : DATA;
            end
            DATA: begin
                data_samp_en = 1'b1;
                deser_en     = (r_edge == w_s);
                if (w_last && r_bit == 4'(DATA_WIDTH)) begin
`ifdef UART_RX_PARITY_SUPPORT_EN
                    w_next = r_par_en ? PARITY : STOP;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_SUPPORT_EN
            PARITY: begin
                data_samp_en = 1'b1;
                par_chk_en   = w_past_s;
                if (w_last) w_next = STOP;
            end
`endif
            STOP: begin
                data_samp_en      = 1'b1;
                stop_check_enable = w_past_s;
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge        <= '0;
            r_bit         <= '0;
            r_prescale    <= '0;
            r_err         <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_SUPPORT_EN
            r_par_en      <= 1'b0;
`endif
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            if (r_state == IDLE) begin
                r_edge <= '0;
                r_bit  <= '0;
                if (!RX_IN) begin
                    r_prescale <= Prescale;
`ifdef UART_RX_PARITY_SUPPORT_EN
                    r_par_en   <= PAR_EN;
`endif
                end
            end else if (w_last) begin
                r_edge <= '0;
                r_bit  <= (w_next == IDLE) ? 4'd0 : r_bit + 4'd1;
`ifdef UART_RX_PARITY_SUPPORT_EN
                if (r_state == PARITY) r_err <= r_err | parity_error;
`endif
                // Result pulses land in the first IDLE cycle after the stop bit.
                if (r_state == STOP) begin
                    r_data_valid  <= !stop_error && !r_err;
                    r_frame_error <= stop_error || r_err;
                end
            end else begin
                r_edge <= r_edge + PRESCALE_WIDTH'(1);
            end
            if (w_next == IDLE) r_err <= 1'b0;
        end
    end

    assign edge_cnt    = r_edge;
    assign bit_cnt     = r_bit;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame sequencer for the UART receiver. Tracks the oversampling edge count and the bit position within a frame. It drives the enables of the data sampler, deserializer, start, parity and stop checkers, and samples their error results at the end of each bit. It issues a one-cycle `data_valid` only for a frame with a clean start bit, correct parity and a correct stop bit.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_WIDTH`, 6: width of `Prescale` and `edge_cnt`.
- `CLK` input 1: receiver clock (oversampling clock).
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line; idle high.
- `PAR_EN` input 1: parity bit present in frame.
- `Prescale` input PRESCALE_WIDTH: oversampling ratio. Legal values are even and ≥ 8 (8/16/32 supported). Sampled only in IDLE.
- `start_glitch` input 1: from start checker; valid while `strt_chk_en`.
- `parity_error` input 1: from parity checker; valid while `par_chk_en`.
- `stop_error` input 1: from stop checker; valid while `stop_check_enable`.
- `data_samp_en` output 1: data sampler enable.
- `deser_en` output 1: one-cycle shift strobe per data bit.
- `strt_chk_en`, `par_chk_en`, `stop_check_enable` output 1: checker enables.
- `edge_cnt` output PRESCALE_WIDTH: current oversample edge within the bit, 0..Prescale−1.
- `bit_cnt` output 4: bit index in frame (0 = start, 1..DATA_WIDTH = data, then parity, then stop).
- `data_valid` output 1: one-cycle frame-good pulse.
- `frame_error` output 1: one-cycle pulse on a parity or stop failure.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Let P = the latched `Prescale`, S = P/2 + 2 (the first edge at which `sampled_bit` is settled), and L = P − 1 (the last edge of a bit).
- **IDLE**:
  - All enables are 0; `edge_cnt` = 0; `bit_cnt` = 0.
  - `RX_IN` = 0 latches `Prescale` and moves to START on the next cycle.
- **Counters**:
  - `edge_cnt` increments every cycle outside IDLE.
  - At L, `edge_cnt` wraps to 0 and `bit_cnt` increments.
- **START**:
  - `data_samp_en` = 1 in every non-IDLE state.
  - `strt_chk_en` = 1 for `edge_cnt` ≥ S.
  - At L: `start_glitch` = 1 → IDLE, with no strobes and no `frame_error`; otherwise → DATA.
- **DATA**:
  - `deser_en` = 1 for exactly one cycle, at `edge_cnt` == S, in each of DATA_WIDTH bits.
  - At L with `bit_cnt` == DATA_WIDTH: → PARITY if the latched `PAR_EN` = 1, else → STOP.
- **PARITY**:
  - `par_chk_en` = 1 for `edge_cnt` ≥ S.
  - At L, `parity_error` is captured into an internal sticky `err` flag; the state → STOP.
- **STOP**:
  - `stop_check_enable` = 1 for `edge_cnt` ≥ S.
  - At L the next cycle → IDLE. In that cycle:
    - `data_valid` = 1 if `stop_error` = 0 and `err` = 0.
    - Otherwise `frame_error` = 1.
  - `err` clears on entering IDLE.
- `PAR_EN` is latched together with `Prescale` in IDLE; changes mid-frame are ignored.
- **Back-to-back frames**: IDLE, entered with `RX_IN` = 0, starts a new frame on the following cycle, giving one IDLE cycle between frames.
- **Counter widths**:
  - `edge_cnt` compare against L uses PRESCALE_WIDTH bits.
  - `bit_cnt` never exceeds DATA_WIDTH + 2.

## Timing
- **Reset**: `RST` low asynchronously forces the following, including mid-frame, with no `data_valid` or `frame_error` emitted:
  - state = IDLE;
  - `edge_cnt` = 0, `bit_cnt` = 0, `err` = 0;
  - every output = 0.
- All outputs are registered or decoded from registered state and counters only; there is no combinational path from `RX_IN`.
- **Frame length** from the first low `RX_IN` cycle to the `data_valid` cycle: 1 + (DATA_WIDTH + 2 + PAR_EN) × P cycles.
- Checker error inputs are sampled only at `edge_cnt` == L of the corresponding state; their values at other cycles are don't-care.

## Configuration
- Macro: `UART_RX_PARITY_SUPPORT_EN`.
- **Defined**: PARITY state, `par_chk_en` and `parity_error` behave as specified above.
- **Undefined**:
  - The PARITY state is not built; DATA always goes to STOP.
  - `PAR_EN` and `parity_error` are ignored.
  - `par_chk_en` is tied to 0.
  - Frame length uses PAR_EN = 0.

## Test plan
- **Good frame**:
  - Stimulus: P=8, PAR_EN=0, data 0xA5, all errors 0.
  - Required: exactly 8 `deser_en` pulses, each at `edge_cnt`=6; `data_valid` high for 1 cycle at cycle 81 after the start edge; `frame_error`=0.
- **Parity error**:
  - Stimulus: P=16, PAR_EN=1, `parity_error`=1 at the parity bit's L.
  - Required: `frame_error` pulses once at cycle 177; `data_valid` stays 0.
- **Stop error**:
  - Stimulus: `stop_error`=1 at the STOP bit's L, P=8.
  - Required: `frame_error`=1 for 1 cycle; FSM back to IDLE; `bit_cnt`=0.
- **Start glitch**:
  - Stimulus: `start_glitch`=1 at START edge 7, P=8.
  - Required: return to IDLE at cycle 9; no `deser_en`, `data_valid` or `frame_error`.
- **Reset mid-DATA**:
  - Stimulus: `RST` low at bit 4, edge 3.
  - Required: all outputs and counters 0 immediately (asynchronously); the next frame after release is received correctly.
- **Back-to-back**:
  - Stimulus: two frames separated by a single idle-high cycle, P=32, PAR_EN=1.
  - Required: two `data_valid` pulses, 353 cycles apart.
